// File: rtl/rr_hold_arbiter_pkg.sv
// rr_hold_arbiter_pkg: shared FSM state encoding and default sizing for the hold arbiter.
package rr_hold_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;
    localparam int DEF_CNT_W    = 4;

endpackage

// File: rtl/rr_hold_arbiter_pick.sv
// rr_pick: round-robin winner select; lowest request above last_ptr, else lowest request overall.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last_ptr,
    output logic [N-1:0] pick
);

    logic [N-1:0] mask, masked, sel;

    // Mask bit i is set when the pointer lies at some position below i.
    always_comb begin
        mask = '0;
        for (int i = 1; i < N; i++) mask[i] = mask[i-1] | last_ptr[i-1];
    end

    assign masked = req & mask;
    assign sel    = |masked ? masked : req;
    assign pick   = sel & (~sel + N'(1));

endmodule

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: round-robin arbiter whose owner holds the grant until done, request drop
// or MAX_HOLD expiry, followed by a one-cycle turnaround gap.
module rr_hold_arbiter
    import rr_hold_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_an,
    input  logic [N-1:0] req,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic         timeout
);

    state_e           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d, last_q, last_d, pick;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d, timeout_q, timeout_d;
    logic             own_req, at_max, rel;

    rr_pick #(.N(N)) u_pick (
        .req      (req),
        .last_ptr (last_q),
        .pick     (pick)
    );

    assign own_req = |(req & grant_q);
    assign at_max  = cnt_q == CNT_W'(MAX_HOLD - 1);
    assign rel     = done || !own_req || at_max;

    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= {1'b1, {(N-1){1'b0}}};
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (|req) state_d = HOLD;
            end
            HOLD: begin
                if (rel) begin
                    state_d = GAP;
                    last_d  = grant_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // done outranks the hold limit, so timeout only fires when nothing else released.
    always_comb begin
        grant_d   = (state_q == IDLE) ? pick :
                    (state_q == HOLD && !rel) ? grant_q : '0;
        busy_d    = |grant_d;
        timeout_d = state_q == HOLD && !done && own_req && at_max;
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter: table-driven, scoreboarded check of rr_hold_arbiter with N=4, MAX_HOLD=8.
module tb_rr_hold_arbiter;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] g;
        logic       t;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_an = 1'b0;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic [3:0] grant;
    logic       busy, timeout;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    rr_hold_arbiter #(.N(4), .MAX_HOLD(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_an  (rst_an),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic d, input logic [3:0] g, input logic t);
        vecs.push_back('{req: r, done: d, g: g, t: t});
    endtask

    initial begin
        vec_t e;
        // Grant to 1, done on third held cycle, gap, then 3 wins.
        add(4'b1010, 0, 4'b0010, 0);
        add(4'b1010, 0, 4'b0010, 0);
        add(4'b1010, 0, 4'b0010, 0);
        add(4'b1010, 1, 4'b0000, 0);
        add(4'b1010, 0, 4'b0000, 0);
        add(4'b1010, 0, 4'b1000, 0);
        // Wrap-around from owner 3 to requester 0.
        add(4'b1001, 0, 4'b1000, 0);
        add(4'b1001, 1, 4'b0000, 0);
        add(4'b1001, 0, 4'b0000, 0);
        add(4'b1001, 0, 4'b0001, 0);
        // Owner drops its request; later done outside HOLD is ignored.
        add(4'b0001, 0, 4'b0001, 0);
        add(4'b0000, 0, 4'b0000, 0);
        add(4'b0000, 0, 4'b0000, 0);
        add(4'b0000, 1, 4'b0000, 0);
        // Hold limit: 8 granted cycles then timeout pulse with grant low.
        for (int i = 0; i < 8; i++) add(4'b0100, 0, 4'b0100, 0);
        add(4'b0100, 0, 4'b0000, 1);
        add(4'b0100, 0, 4'b0000, 0);
        add(4'b0100, 0, 4'b0100, 0);
        // Non-owner requests ignored; done coincides with the last hold cycle.
        for (int i = 0; i < 7; i++) add(4'b1111, 0, 4'b0100, 0);
        add(4'b1111, 1, 4'b0000, 0);
        add(4'b1111, 0, 4'b0000, 0);
        add(4'b1111, 0, 4'b1000, 0);

        #12;
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);
        @(negedge clk);
        rst_an = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            req  = vecs[i].req;
            done = vecs[i].done;
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(e.g));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(|e.g));
            chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'(e.t));
        end

        // Asynchronous reset while requester 3 owns the resource.
        @(negedge clk);
        done   = 1'b0;
        rst_an = 1'b0;
        #1;
        chk("async_rst_grant", 32'(grant), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_an = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_grant", 32'(grant), 32'h1);
        chk("post_rst_busy", 32'(busy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
